// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing over one shared bus port.
// Optional feature: define RV_CTRL_TRAP_EN to trap on unrecognised opcodes (otherwise they retire as NOPs).
module rv_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  imm_type,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  state_t     state, next;
  logic [6:0] opcode;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, is_fence;
  logic       dec_a_sel, dec_b_sel;
  logic [1:0] dec_alu_op;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^inst[31:7];

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);

  assign state_o = state;

`ifdef RV_CTRL_TRAP_EN
  assign illegal = (state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    imm_type = 3'd0;
    if (state != S_IDLE) begin
      if (is_lui || is_auipc)                                 imm_type = 3'd0;
      else if (is_jal)                                        imm_type = 3'd1;
      else if (is_jalr || is_load || is_opimm || is_op || is_fence) imm_type = 3'd2;
      else if (is_store)                                      imm_type = 3'd3;
      else if (is_branch)                                     imm_type = 3'd4;
    end
  end

  // ALU selects stay valid through MEM and WB so the address / jump target remains stable
  always_comb begin
    dec_a_sel  = 1'b0;
    dec_b_sel  = 1'b0;
    dec_alu_op = 2'd0;
    if (is_op) begin
      dec_alu_op = 2'd2;
    end else if (is_opimm) begin
      dec_b_sel  = 1'b1;
      dec_alu_op = 2'd2;
    end else if (is_load || is_store || is_jal || is_jalr) begin
      dec_b_sel  = 1'b1;
    end else if (is_lui) begin
      dec_b_sel  = 1'b1;
      dec_alu_op = 2'd3;
    end else if (is_auipc) begin
      dec_a_sel  = 1'b1;
      dec_b_sel  = 1'b1;
    end else if (is_branch) begin
      dec_alu_op = 2'd1;
    end
  end

  always_comb begin
    next      = state;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;

    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      alu_a_sel = dec_a_sel;
      alu_b_sel = dec_b_sel;
      alu_op    = dec_alu_op;
    end

    case (state)
      S_IDLE:   next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          next  = S_DECODE;
        end
      end
      S_DECODE: next = S_EXEC;
      S_EXEC: begin
        if (is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr) begin
          next = S_WB;
        end else if (is_load || is_store) begin
          next = S_MEM;
        end else if (is_branch) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? 2'd1 : 2'd0;
          next   = S_FETCH;
        end else if (is_fence) begin
          pc_we = 1'b1;
          next  = S_FETCH;
        end else begin
`ifdef RV_CTRL_TRAP_EN
          next = S_TRAP;
`else
          pc_we = 1'b1;
          next  = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we = 1'b1;
            next  = S_FETCH;
          end else begin
            next  = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_src = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        next   = S_FETCH;
      end
      S_TRAP:   next = S_TRAP;
      default:  next = S_IDLE;
    endcase
  end

endmodule
